// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the fully connected MNIST layer sequencer.
package nn_pkg;

    localparam int N_IN   = 784;
    localparam int N_OUT  = 10;
    localparam int ACC_W  = 32;
    localparam int X_AW   = 10;
    localparam int W_AW   = 13;
    localparam int B_AW   = 4;
    localparam int IDX_W  = 4;
    // {1'b0, 8-bit pixel} x signed 8-bit weight always fits in 17 signed bits
    localparam int PROD_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_FINISH,
        S_DONE
    } state_t;

endpackage

// File: rtl/nn_layer_ctrl_if.sv
// Memory-side bus: pixel buffer read port plus weight and bias ROM ports.
interface nn_layer_ctrl_if
    import nn_pkg::*;
#(
    parameter int X_AW  = nn_pkg::X_AW,
    parameter int W_AW  = nn_pkg::W_AW,
    parameter int B_AW  = nn_pkg::B_AW,
    parameter int ACC_W = nn_pkg::ACC_W
);
    logic                    x_rd_en;
    logic [X_AW-1:0]         x_addr;
    logic [7:0]              x_data;
    logic                    w_en;
    logic [W_AW-1:0]         w_addr;
    logic signed [7:0]       w_dout;
    logic                    b_en;
    logic [B_AW-1:0]         b_addr;
    logic signed [ACC_W-1:0] b_dout;

    modport master (
        output x_rd_en, x_addr, w_en, w_addr, b_en, b_addr,
        input  x_data, w_dout, b_dout
    );

    modport slave (
        input  x_rd_en, x_addr, w_en, w_addr, b_en, b_addr,
        output x_data, w_dout, b_dout
    );
endinterface

// File: rtl/nn_mac.sv
// Neuron accumulator: loads the bias, adds pixel*weight products (wrapping), exposes ReLU.
module nn_mac
    import nn_pkg::*;
#(
    parameter int ACC_W = nn_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    add,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [7:0]              x_data,
    input  logic signed [7:0]       w_dout,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] relu
);

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    assign x_ext = {{(PROD_W-8){1'b0}}, x_data};
    assign w_ext = {{(PROD_W-8){w_dout[7]}}, w_dout};
    assign prod  = x_ext * w_ext;

    generate
        if (ACC_W > PROD_W) begin : g_sext
            assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end else if (ACC_W == PROD_W) begin : g_same
            assign prod_ext = prod;
        end else begin : g_trunc
            assign prod_ext = prod[ACC_W-1:0];
        end
    endgenerate

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = bias;
        end else if (add) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc  = acc_q;
    // ReLU acts on the wrapped accumulator, so an overflow into the sign bit reads as negative
    assign relu = acc_q[ACC_W-1] ? '0 : acc_q;

endmodule

// File: rtl/nn_layer_ctrl.sv
// Sequences one fully connected layer: per neuron BIAS, N_IN MAC cycles, DRAIN, FINISH;
// streams ReLU scores and tracks the argmax class.
module nn_layer_ctrl
    import nn_pkg::*;
#(
    parameter int N_IN  = nn_pkg::N_IN,
    parameter int N_OUT = nn_pkg::N_OUT,
    parameter int ACC_W = nn_pkg::ACC_W,
    parameter int X_AW  = nn_pkg::X_AW,
    parameter int W_AW  = nn_pkg::W_AW,
    parameter int B_AW  = nn_pkg::B_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    nn_layer_ctrl_if.master         mem,
    output logic                    score_valid,
    output logic [IDX_W-1:0]        score_idx,
    output logic signed [ACC_W-1:0] score,
    output logic [IDX_W-1:0]        predicted,
    output logic signed [ACC_W-1:0] max_score
);

    state_t                  state_q, state_d;
    logic [X_AW-1:0]         i_q, i_d;
    logic [W_AW-1:0]         w_cnt_q, w_cnt_d;
    logic [IDX_W-1:0]        j_q, j_d;
    logic                    done_q, done_d;
    logic [IDX_W-1:0]        pred_q, pred_d;
    logic signed [ACC_W-1:0] max_q, max_d;

    logic                    mac_load;
    logic                    mac_add;
    logic signed [ACC_W-1:0] acc_val;
    logic signed [ACC_W-1:0] relu_score;

    logic in_bias, in_mac, in_finish;
    logic last_i, last_j;

    assign in_bias   = (state_q == S_BIAS);
    assign in_mac    = (state_q == S_MAC);
    assign in_finish = (state_q == S_FINISH);
    assign last_i    = (i_q == X_AW'(N_IN - 1));
    assign last_j    = (j_q == IDX_W'(N_OUT - 1));

    nn_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .load   (mac_load),
        .add    (mac_add),
        .bias   (mem.b_dout),
        .x_data (mem.x_data),
        .w_dout (mem.w_dout),
        .acc    (acc_val),
        .relu   (relu_score)
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        w_cnt_d  = w_cnt_q;
        j_d      = j_q;
        pred_d   = pred_q;
        max_d    = max_q;
        mac_load = 1'b0;
        mac_add  = 1'b0;
        // done is registered off the DONE state so it rises as busy falls
        done_d   = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BIAS;
                    j_d     = '0;
                    i_d     = '0;
                    w_cnt_d = '0;
                end
            end
            S_BIAS: begin
                state_d = S_MAC;
                i_d     = '0;
            end
            S_MAC: begin
                // Bias data lands in the first MAC cycle; products lag their reads by one cycle
                mac_load = (i_q == '0);
                mac_add  = (i_q != '0);
                w_cnt_d  = w_cnt_q + 1'b1;
                if (last_i) begin
                    i_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_DRAIN: begin
                mac_add = 1'b1;
                state_d = S_FINISH;
            end
            S_FINISH: begin
                if ((j_q == '0) || (relu_score > max_q)) begin
                    max_d  = relu_score;
                    pred_d = j_q;
                end
                if (last_j) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = S_BIAS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            w_cnt_q <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
            pred_q  <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            w_cnt_q <= w_cnt_d;
            j_q     <= j_d;
            done_q  <= done_d;
            pred_q  <= pred_d;
            max_q   <= max_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

    assign mem.b_en    = in_bias;
    assign mem.b_addr  = in_bias ? B_AW'(j_q) : '0;
    assign mem.x_rd_en = in_mac;
    assign mem.x_addr  = in_mac ? i_q : '0;
    assign mem.w_en    = in_mac;
    assign mem.w_addr  = in_mac ? w_cnt_q : '0;

    assign score_valid = in_finish;
    assign score_idx   = in_finish ? j_q : '0;
    assign score       = in_finish ? relu_score : '0;
    assign predicted   = pred_q;
    assign max_score   = max_q;

endmodule

// File: tb/tb_nn_layer_ctrl.sv
// Self-checking bench for nn_layer_ctrl: table-driven full-layer runs plus restart, abort and 16-bit wrap sequences.
module tb_nn_layer_ctrl;
    import nn_pkg::*;

    localparam int DONE_EDGE = 10 * (784 + 3) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic start16 = 1'b0;

    always #5 clk = ~clk;

    nn_layer_ctrl_if #(.X_AW(10), .W_AW(13), .B_AW(4), .ACC_W(32)) mem ();
    nn_layer_ctrl_if #(.X_AW(10), .W_AW(13), .B_AW(4), .ACC_W(16)) mem16 ();

    logic               busy, done, score_valid;
    logic [3:0]         score_idx, predicted;
    logic signed [31:0] score, max_score;

    logic               busy16, done16, score_valid16;
    logic [3:0]         score_idx16, predicted16;
    logic signed [15:0] score16, max_score16;

    nn_layer_ctrl #(.N_IN(784), .N_OUT(10), .ACC_W(32), .X_AW(10), .W_AW(13), .B_AW(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem         (mem),
        .score_valid (score_valid),
        .score_idx   (score_idx),
        .score       (score),
        .predicted   (predicted),
        .max_score   (max_score)
    );

    nn_layer_ctrl #(.N_IN(784), .N_OUT(10), .ACC_W(16), .X_AW(10), .W_AW(13), .B_AW(4)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .busy        (busy16),
        .done        (done16),
        .mem         (mem16),
        .score_valid (score_valid16),
        .score_idx   (score_idx16),
        .score       (score16),
        .predicted   (predicted16),
        .max_score   (max_score16)
    );

    // ROM / pixel buffer models, 1-cycle read latency
    int x_mode = 0;
    int w_mode = 0;
    int b_mode = 0;

    function automatic logic signed [7:0] w_of(input int a);
        if (w_mode == 0) return 8'sd0;
        return ((a / 784) == 7) ? 8'sd1 : -8'sd1;
    endfunction

    function automatic logic signed [31:0] b_of(input int j);
        if (b_mode == 0) return 32'(10 * j);
        if (b_mode == 1) return 32'sd5;
        return 32'sd0;
    endfunction

    always @(posedge clk) begin
        if (mem.x_rd_en) mem.x_data <= (x_mode == 0) ? (mem.x_addr[7:0] ^ 8'h5a) : 8'd255;
        if (mem.w_en)    mem.w_dout <= w_of(int'(mem.w_addr));
        if (mem.b_en)    mem.b_dout <= b_of(int'(mem.b_addr));
        if (mem16.x_rd_en) mem16.x_data <= 8'd255;
        if (mem16.w_en)    mem16.w_dout <= 8'sd127;
        if (mem16.b_en)    mem16.b_dout <= 16'sd0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: score capture, done counting and address-sequence checking
    int run_id = 0;
    int mon_run = 0;
    int sv_cnt, addr_err, b_cnt, w_cnt, done_cnt;
    int b_exp, w_exp, x_exp;
    logic signed [31:0] sc [10];
    int sc16_cnt = 0;
    int bad16 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_run != run_id) begin
                mon_run  = run_id;
                sv_cnt   = 0; addr_err = 0; b_cnt = 0; w_cnt = 0; done_cnt = 0;
                b_exp    = 0; w_exp    = 0; x_exp = 0;
                for (int k = 0; k < 10; k++) sc[k] = '0;
            end
            if (done) done_cnt++;
            if (score_valid) begin
                sc[score_idx] = score;
                sv_cnt++;
            end
            if (mem.b_en) begin
                if (int'(mem.b_addr) != b_exp) addr_err++;
                b_exp++;
                b_cnt++;
            end else if (mem.b_addr != '0) addr_err++;
            if (mem.w_en != mem.x_rd_en) addr_err++;
            if (mem.b_en && mem.w_en) addr_err++;
            if (mem.w_en) begin
                if (int'(mem.w_addr) != w_exp) addr_err++;
                w_exp++;
                w_cnt++;
            end else if (mem.w_addr != '0) addr_err++;
            if (mem.x_rd_en) begin
                if (int'(mem.x_addr) != x_exp) addr_err++;
                x_exp = (x_exp == 783) ? 0 : x_exp + 1;
            end else if (mem.x_addr != '0) addr_err++;
            if (score_valid16) begin
                sc16_cnt++;
                if (score16 != 16'sd27408) bad16++;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Launches a run and waits for done; optionally pokes start or asserts reset mid-run.
    task automatic launch_and_wait(input int poke_at, input int abort_at, output int done_edge);
        int e0;
        int k;
        done_edge = -1;
        run_id++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
        k  = 0;
        while (k < 8000) begin
            if (done) begin
                done_edge = cyc - e0;
                break;
            end
            start = (poke_at > 0) && (k == poke_at);
            if ((abort_at > 0) && (k == abort_at)) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                done_edge = 0;
                return;
            end
            @(negedge clk);
            k = cyc - e0;
        end
        start = 1'b0;
        if (done_edge < 0) chk("done_timeout", 1, 0);
    endtask

    typedef struct packed {
        int               x_mode;
        int               w_mode;
        int               b_mode;
        int               exp_pred;
        int               exp_max;
        logic [9:0][31:0] exp_score;
    } vec_t;

    vec_t vecs [3];

    task automatic check_run(input string tag, input vec_t v, input int de);
        chk({tag, "_done_edge"}, de, DONE_EDGE);
        chk({tag, "_score_pulses"}, sv_cnt, 10);
        for (int j = 0; j < 10; j++)
            chk($sformatf("%s_score%0d", tag, j), longint'(sc[j]), longint'($signed(v.exp_score[j])));
        chk({tag, "_predicted"}, predicted, v.exp_pred);
        chk({tag, "_max_score"}, longint'(max_score), v.exp_max);
        chk({tag, "_addr_seq"}, addr_err, 0);
        chk({tag, "_b_reads"}, b_cnt, 10);
        chk({tag, "_w_reads"}, w_cnt, 7840);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        $display("run %s: done_edge=%0d predicted=%0d max_score=%0d pulses=%0d", tag, de, predicted, max_score, sv_cnt);
    endtask

    initial begin
        int de;
        int e0;
        int k;
        int dc_before;

        vecs[0].x_mode = 0; vecs[0].w_mode = 0; vecs[0].b_mode = 0;
        vecs[0].exp_pred = 9; vecs[0].exp_max = 90;
        for (int j = 0; j < 10; j++) vecs[0].exp_score[j] = 32'(10 * j);
        vecs[1].x_mode = 0; vecs[1].w_mode = 0; vecs[1].b_mode = 1;
        vecs[1].exp_pred = 0; vecs[1].exp_max = 5;
        for (int j = 0; j < 10; j++) vecs[1].exp_score[j] = 32'd5;
        vecs[2].x_mode = 1; vecs[2].w_mode = 1; vecs[2].b_mode = 2;
        vecs[2].exp_pred = 7; vecs[2].exp_max = 199920;
        for (int j = 0; j < 10; j++) vecs[2].exp_score[j] = (j == 7) ? 32'd199920 : 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enables", {mem.x_rd_en, mem.w_en, mem.b_en, score_valid}, 0);
        chk("rst_predicted", predicted, 0);
        chk("rst_max_score", longint'(max_score), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 3; t++) begin
            x_mode = vecs[t].x_mode;
            w_mode = vecs[t].w_mode;
            b_mode = vecs[t].b_mode;
            launch_and_wait(0, 0, de);
            repeat (5) @(negedge clk);
            check_run($sformatf("vec%0d", t), vecs[t], de);
        end

        // start pulsed mid-run must be ignored
        launch_and_wait(50, 0, de);
        repeat (20) @(negedge clk);
        check_run("restart_ignored", vecs[2], de);
        chk("restart_busy_after", busy, 0);

        // Reset mid-run aborts with no done
        x_mode = vecs[0].x_mode; w_mode = vecs[0].w_mode; b_mode = vecs[0].b_mode;
        launch_and_wait(0, 100, de);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_enables", {mem.x_rd_en, mem.w_en, mem.b_en, score_valid}, 0);
        chk("abort_addrs", {mem.x_addr, mem.w_addr, mem.b_addr}, 0);
        chk("abort_predicted", predicted, 0);
        chk("abort_max_score", longint'(max_score), 0);
        chk("abort_score", longint'(score), 0);
        dc_before = done_cnt;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt - dc_before, 0);
        chk("abort_idle_busy", busy, 0);
        $display("run abort: busy=%0d predicted=%0d", busy, predicted);

        launch_and_wait(0, 0, de);
        repeat (5) @(negedge clk);
        check_run("fresh", vecs[0], de);

        // 16-bit accumulator: 784*255*127 wraps to 27408 for every neuron
        @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        e0 = cyc;
        k  = 0;
        de = -1;
        while (k < 8000) begin
            if (done16) begin
                de = cyc - e0;
                break;
            end
            @(negedge clk);
            k = cyc - e0;
        end
        if (de < 0) chk("acc16_done_timeout", 1, 0);
        chk("acc16_done_edge", de, DONE_EDGE);
        chk("acc16_score_pulses", sc16_cnt, 10);
        chk("acc16_bad_scores", bad16, 0);
        chk("acc16_predicted", predicted16, 0);
        chk("acc16_max_score", longint'(max_score16), 27408);
        $display("run acc16: done_edge=%0d predicted=%0d max_score=%0d", de, predicted16, max_score16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_layer_ctrl.md
Name: nn_layer_ctrl

Overview:
Sequencer for one fully connected layer of the MNIST classifier: walks N_OUT neurons × N_IN pixels, reads the pixel buffer plus weight/bias ROMs, and accumulates with MAC. Applies ReLU, streams scores, and returns argmax as the predicted class. Sits between the AXI register block (start/done/predicted) and the BD ROMs.

Parameters:
N_IN, 784, inputs per neuron (pixel buffer depth)
N_OUT, 10, neurons / classes
ACC_W, 32, accumulator and score width, signed
X_AW, 10, pixel address width
W_AW, 13, weight ROM address width (≥ clog2(N_IN*N_OUT))
B_AW, 4, bias ROM address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start  in  1  launch request, sampled only in IDLE
busy  out  1  high from the accepting edge until done; AXI side blocks pixel writes while high
done  out  1  one-cycle pulse, registered
x_rd_en  out  1  pixel buffer read enable
x_addr  out  X_AW  pixel address
x_data  in  8  unsigned pixel, valid 1 cycle after read
w_en  out  1  weight ROM enable
w_addr  out  W_AW  weight address = j*N_IN+i
w_dout  in  8  signed weight, 1-cycle latency
b_en  out  1  bias ROM enable
b_addr  out  B_AW  bias address = j
b_dout  in  ACC_W  signed bias, 1-cycle latency
score_valid  out  1  pulse, one per neuron
score_idx  out  4  neuron index j
score  out  ACC_W  post-ReLU score
predicted  out  4  argmax class
max_score  out  ACC_W  winning score

Behaviour:
- Reset (rst=0 at edge): state IDLE; busy, done, x_rd_en, w_en, b_en, score_valid = 0; all addresses, score_idx, score, predicted, max_score = 0; counters cleared. Reset mid-run aborts immediately, with no done pulse.
- States: IDLE → BIAS → MAC → DRAIN → FINISH → (BIAS for next j | DONE) → IDLE.
- IDLE: start=1 → BIAS, j=0, busy=1.
- BIAS (1 cycle): b_en=1, b_addr=j.
- MAC (N_IN cycles, i=0..N_IN-1): x_rd_en=w_en=1, x_addr=i, w_addr = running counter (incremented, no multiplier).
  - First MAC cycle: acc ← b_dout.
  - Later cycles: acc += product of the read issued in the previous cycle.
- DRAIN (1 cycle): enables low; acc += last product.
- FINISH (1 cycle): score = max(acc,0); score_valid=1; score_idx=j.
  - Argmax update if j==0 or score > max_score (strict; ties keep lower index).
  - j==N_OUT-1 → DONE, else j++ → BIAS.
- DONE (1 cycle): done=1; busy drops next cycle; → IDLE. predicted/max_score hold until the next run's first FINISH.
- Cycles per neuron: N_IN+3. done is high in the cycle beginning N_OUT*(N_IN+3)+1 edges after the start-accepting edge (7871 at defaults).
- Arithmetic:
  - product = {1'b0,x_data} × signed w_dout (17-bit signed), sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W with no saturation.
  - ReLU compares on the wrapped value.
- start while busy is ignored (not queued). start held high through DONE relaunches from IDLE on the following edge.
- Enables are low and addresses are 0 outside their states.

Decomposition:
- Package nn_pkg holds N_IN, N_OUT, ACC_W, the address widths, the state enum, and the product width constant (17).
- Sub-module nn_mac: accumulator with load (bias), add (product), and ReLU output. Keeps FSM and arithmetic separate.

Test Plan:
- Weights 0, b[j]=10*j, any pixels → scores 0,10,…,90; predicted=9, max_score=90; done at edge 7871; exactly 10 score_valid pulses.
- All biases 5, weights 0 → tie: predicted=0, max_score=5.
- x all 255, w=-1 for all neurons except j=7 (w=+1), biases 0 → score7=199920, others 0; predicted=7.
- ACC_W=16, x=255, w=127, bias 0 → every score 27408 (25389840 mod 65536); predicted=0.
- Pulse start again at cycle 50 of a run → no effect, single done. rst=0 at cycle 100 → all outputs 0, busy 0, no done; fresh start completes normally.
- Address check: b_addr 0..9 once each; w_addr contiguous 0..7839; x_addr 0..783 per neuron; enables never high outside BIAS/MAC.
